calc1_scheduler: RTL and testbench
==================================

CALC1_SCHEDULER -- requirements
Module: calc1_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum cycles to wait for alu_done after issue (legal range 2..255).
REQ-002 c_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 reqN_cmd_in (N=1..4)  input  [0:3]  SHALL carry the requester command: 0 none, 1 add, 2 sub, 5 shift-left, 6 shift-right; all other values are invalid.
REQ-005 reqN_data_in (N=1..4)  input  [0:31]  SHALL carry operand1 in the command cycle and operand2 in the following cycle.
REQ-006 out_respN (N=1..4)  output  [0:1]  SHALL carry the response code: 0 none, 1 success, 2 overflow/invalid/timeout.
REQ-007 out_dataN (N=1..4)  output  [0:31]  SHALL carry the result and be valid only while out_respN != 0.
REQ-008 alu_valid  output  1  SHALL pulse for one cycle to issue an operation to the shared ALU.
REQ-009 alu_cmd  output  [0:3]; alu_op1, alu_op2  output  [0:31]  SHALL carry the issued command and operands, held stable from issue until the response cycle.
REQ-010 alu_done  input  1  SHALL be a one-cycle pulse from the ALU marking completion.
REQ-011 alu_resp  input  [0:1]; alu_result  input  [0:31]  SHALL carry the ALU response code and result, sampled when alu_done=1.

Function
REQ-012 Each port SHALL have a capture FSM P_IDLE -> P_OP2 -> P_PEND: in P_IDLE, cmd!=0 latches cmd and operand1 and moves to P_OP2; the next cycle latches operand2 unconditionally and moves to P_PEND.
REQ-013 In P_PEND or P_OP2, a new reqN_cmd_in!=0 SHALL be dropped without changing latched values; one outstanding request per port.
REQ-014 In P_OP2, an invalid cmd SHALL move to P_PEND flagged invalid; the port SHALL still be arbitrated, but no ALU issue occurs.
REQ-015 The main FSM SHALL use states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any port is in P_PEND, grant the first pending port at or after rr_ptr (cyclic 1->2->3->4->1); go to ISSUE, or to RESP with resp=2 and data=0 if the granted request is invalid.
REQ-017 ISSUE SHALL last one cycle with alu_valid=1, start the timeout counter at 0, then enter WAIT.
REQ-018 WAIT SHALL increment the counter each cycle; alu_done=1 captures alu_resp/alu_result and enters RESP; counter reaching TIMEOUT with no done enters RESP with resp=2, data=0.
REQ-019 alu_done and timeout in the same cycle SHALL resolve as done; alu_done outside WAIT SHALL be ignored.
REQ-020 RESP SHALL last one cycle and drive out_respN/out_dataN of the granted port only; all other ports SHALL output 0/0; then the granted port returns to P_IDLE, rr_ptr = grant+1 (4 wraps to 1), and the FSM returns to IDLE.
REQ-021 A port released in RESP SHALL accept a new command in the following cycle.
REQ-022 Minimum latency: command at cycle T with alu_done at T+4 SHALL give the response at T+5.
REQ-023 The scheduler SHALL NOT compute arithmetic; result width and overflow are those reported by the ALU, passed through unmodified.

Reset
REQ-024 Asserting reset SHALL immediately clear all outputs to 0, all port FSMs to P_IDLE, the main FSM to IDLE, rr_ptr to 1, and the counter to 0.
REQ-025 Reset mid-operation SHALL abandon any in-flight request without a response; alu_done arriving after reset release SHALL be ignored.
REQ-026 Deassertion SHALL be synchronised so the first command is accepted no earlier than the second rising edge after release.

Verification
REQ-027 Port1 add, op1=1, op2=0x14FFFFFE; ALU returns resp=1 and result=0x14FFFFFF -> out_resp1=1, out_data1=0x14FFFFFF at T+5; all other ports 0.
REQ-028 All four ports issue add in the same cycle, rr_ptr=1 -> ALU issues in order 1,2,3,4; exactly one response per port; next grant after port4 goes to port1.
REQ-029 Port3 cmd=7 (invalid) -> out_resp3=2, out_data3=0; alu_valid never asserted.
REQ-030 Port2 add with ALU silent, TIMEOUT=15 -> out_resp2=2 exactly 16 cycles after issue; with alu_done in that 16th cycle -> ALU response returned instead.
REQ-031 Port4 sends a second command while pending -> second command dropped; exactly one response, carrying the first operands.
REQ-032 Reset asserted during WAIT with a late alu_done -> all outputs 0, no response ever, rr_ptr=1.

Source files
------------

// File: rtl/calc1_scheduler.sv
// calc1_scheduler: four requester ports share one ALU. Each port captures a
// two-cycle command (cmd+operand1, then operand2), a round-robin main FSM
// issues pending requests to the ALU one at a time, waits for completion
// or timeout, and returns the response to the originating port only.
module calc1_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic        alu_valid,
  output logic [0:3]  alu_cmd,
  output logic [0:31] alu_op1,
  output logic [0:31] alu_op2,
  input  logic        alu_done,
  input  logic [0:1]  alu_resp,
  input  logic [0:31] alu_result
);

  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} port_state_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] RESP_ERR = 2'd2;

  // Only add, sub, shift-left and shift-right are forwarded to the ALU.
  function automatic logic cmd_ok(input logic [0:3] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // Reset release is pipelined through two flops so no command is taken
  // on the first edges after the asynchronous reset lets go.
  logic [1:0] sync_reg;
  logic       run;

  // Reset-release synchroniser.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], 1'b1};
  end

  assign run = sync_reg[1];

  // Per-port request inputs gathered into arrays for the generate loop.
  logic [0:3]  cmd_in  [4];
  logic [0:31] data_in [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Latched request contents seen by the main FSM.
  logic [0:3]  port_cmd [4];
  logic [0:31] port_op1 [4];
  logic [0:31] port_op2 [4];
  logic [3:0]  pend;
  logic [3:0]  inv;
  logic [3:0]  rel;
  logic [0:1]  resp_arr [4];
  logic [0:31] data_arr [4];

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic [1:0]  rr_reg, rr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [0:1]  resp_reg, resp_next;
  logic [0:31] data_reg, data_next;
  logic [0:3]  alu_cmd_reg, alu_cmd_next;
  logic [0:31] op1_reg, op1_next;
  logic [0:31] op2_reg, op2_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_port
      port_state_t pstate_reg, pstate_next;
      logic [0:3]  cmd_reg;
      logic [0:31] op1_reg_p;
      logic [0:31] op2_reg_p;
      logic        bad_reg;

      // Capture state and operands; commands arriving outside P_IDLE are dropped.
      always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
          pstate_reg <= P_IDLE;
          cmd_reg    <= '0;
          op1_reg_p  <= '0;
          op2_reg_p  <= '0;
          bad_reg    <= 1'b0;
        end else begin
          pstate_reg <= pstate_next;
          if (pstate_reg == P_IDLE && run && cmd_in[gi] != 4'd0) begin
            cmd_reg   <= cmd_in[gi];
            op1_reg_p <= data_in[gi];
          end
          if (pstate_reg == P_OP2) begin
            op2_reg_p <= data_in[gi];
            bad_reg   <= !cmd_ok(cmd_reg);
          end
        end
      end

      // Port capture next-state: IDLE -> OP2 -> PEND, released by the main FSM.
      always_comb begin
        pstate_next = pstate_reg;
        case (pstate_reg)
          P_IDLE:  if (run && cmd_in[gi] != 4'd0) pstate_next = P_OP2;
          P_OP2:   pstate_next = P_PEND;
          P_PEND:  if (rel[gi]) pstate_next = P_IDLE;
          default: pstate_next = P_IDLE;
        endcase
      end

      assign pend[gi]     = (pstate_reg == P_PEND);
      assign inv[gi]      = bad_reg;
      assign port_cmd[gi] = cmd_reg;
      assign port_op1[gi] = op1_reg_p;
      assign port_op2[gi] = op2_reg_p;
      assign rel[gi]      = (state_reg == RESP) && (grant_reg == 2'(gi));
      assign resp_arr[gi] = rel[gi] ? resp_reg : 2'd0;
      assign data_arr[gi] = rel[gi] ? data_reg : 32'd0;
    end
  endgenerate

  // Round-robin pick: first pending port at or after rr_reg, wrapping.
  logic [1:0] pick;
  logic       found;
  logic [1:0] cand;

  // Cyclic priority search starting at the round-robin pointer.
  always_comb begin
    pick  = rr_reg;
    found = 1'b0;
    cand  = rr_reg;
    for (int k = 0; k < 4; k++) begin
      cand = rr_reg + k[1:0];
      if (!found && pend[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Main FSM registers and the issued/returned payload.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 2'd0;
      rr_reg      <= 2'd0;
      cnt_reg     <= 8'd0;
      resp_reg    <= 2'd0;
      data_reg    <= 32'd0;
      alu_cmd_reg <= 4'd0;
      op1_reg     <= 32'd0;
      op2_reg     <= 32'd0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_reg      <= rr_next;
      cnt_reg     <= cnt_next;
      resp_reg    <= resp_next;
      data_reg    <= data_next;
      alu_cmd_reg <= alu_cmd_next;
      op1_reg     <= op1_next;
      op2_reg     <= op2_next;
    end
  end

  // Main FSM next-state: grant, issue, wait for done/timeout, respond.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_next      = rr_reg;
    cnt_next     = cnt_reg;
    resp_next    = resp_reg;
    data_next    = data_reg;
    alu_cmd_next = alu_cmd_reg;
    op1_next     = op1_reg;
    op2_next     = op2_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          if (inv[pick]) begin
            // Invalid requests are answered directly without touching the ALU.
            state_next = RESP;
            resp_next  = RESP_ERR;
            data_next  = 32'd0;
          end else begin
            state_next   = ISSUE;
            alu_cmd_next = port_cmd[pick];
            op1_next     = port_op1[pick];
            op2_next     = port_op2[pick];
          end
        end
      end
      ISSUE: begin
        cnt_next   = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        // Done takes priority over a timeout landing in the same cycle.
        if (alu_done) begin
          resp_next  = alu_resp;
          data_next  = alu_result;
          state_next = RESP;
        end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
          resp_next  = RESP_ERR;
          data_next  = 32'd0;
          state_next = RESP;
        end
      end
      RESP: begin
        rr_next    = grant_reg + 2'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign alu_valid = (state_reg == ISSUE);
  assign alu_cmd   = alu_cmd_reg;
  assign alu_op1   = op1_reg;
  assign alu_op2   = op2_reg;

  assign out_resp1 = resp_arr[0];
  assign out_resp2 = resp_arr[1];
  assign out_resp3 = resp_arr[2];
  assign out_resp4 = resp_arr[3];
  assign out_data1 = data_arr[0];
  assign out_data2 = data_arr[1];
  assign out_data3 = data_arr[2];
  assign out_data4 = data_arr[3];

endmodule

// File: tb/tb_calc1_scheduler.sv
// Directed bench for calc1_scheduler: single path, basic transfer,
// round-robin ordering, invalid command, timeout, dropped commands, reset.
module tb_calc1_scheduler;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic        alu_valid;
  logic [0:3]  alu_cmd;
  logic [0:31] alu_op1, alu_op2;
  logic        alu_done;
  logic [0:1]  alu_resp;
  logic [0:31] alu_result;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int rcnt [4] = '{0, 0, 0, 0};
  int v0, r0;

  calc1_scheduler #(.TIMEOUT(15)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req1_cmd_in), .req2_cmd_in(req2_cmd_in),
    .req3_cmd_in(req3_cmd_in), .req4_cmd_in(req4_cmd_in),
    .req1_data_in(req1_data_in), .req2_data_in(req2_data_in),
    .req3_data_in(req3_data_in), .req4_data_in(req4_data_in),
    .out_resp1(out_resp1), .out_resp2(out_resp2),
    .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_result(alu_result)
  );

  always #5 c_clk = ~c_clk;

  // Count issue pulses and response cycles per port, sampled mid-cycle.
  always @(negedge c_clk) begin
    if (alu_valid === 1'b1) vcnt++;
    if (out_resp1 !== 2'd0) rcnt[0]++;
    if (out_resp2 !== 2'd0) rcnt[1]++;
    if (out_resp3 !== 2'd0) rcnt[2]++;
    if (out_resp4 !== 2'd0) rcnt[3]++;
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] resp_of(input int p);
    case (p)
      1: return out_resp1;
      2: return out_resp2;
      3: return out_resp3;
      default: return out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input int p);
    case (p)
      1: return out_data1;
      2: return out_data2;
      3: return out_data3;
      default: return out_data4;
    endcase
  endfunction

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      1: begin req1_cmd_in = c; req1_data_in = d; end
      2: begin req2_cmd_in = c; req2_data_in = d; end
      3: begin req3_cmd_in = c; req3_data_in = d; end
      default: begin req4_cmd_in = c; req4_data_in = d; end
    endcase
  endtask

  task automatic others_zero(input int p);
    for (int q = 1; q <= 4; q++)
      if (q != p) chk($sformatf("resp%0d_quiet", q), 32'(resp_of(q)), 32'd0);
  endtask

  // Wait (bounded) for an issue, check operands, answer with success.
  task automatic serve(input int p, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] res);
    int w;
    w = 0;
    while (alu_valid !== 1'b1 && w < 12) begin
      tick();
      w++;
    end
    chk($sformatf("issue_seen_p%0d", p), 32'(alu_valid), 32'd1);
    chk($sformatf("alu_cmd_p%0d", p), 32'(alu_cmd), 32'd1);
    chk($sformatf("alu_op1_p%0d", p), alu_op1, e1);
    chk($sformatf("alu_op2_p%0d", p), alu_op2, e2);
    tick();
    alu_done = 1'b1; alu_resp = 2'd1; alu_result = res;
    tick();
    alu_done = 1'b0; alu_resp = 2'd0; alu_result = 32'd0;
    chk($sformatf("resp_p%0d", p), 32'(resp_of(p)), 32'd1);
    chk($sformatf("data_p%0d", p), data_of(p), res);
    others_zero(p);
    $display("txn port%0d op1=%h op2=%h resp=%0d data=%h", p, e1, e2, resp_of(p), data_of(p));
  endtask

  initial begin
    reset = 1'b0;
    for (int p = 1; p <= 4; p++) set_req(p, 4'd0, 32'd0);
    alu_done = 1'b0; alu_resp = 2'd0; alu_result = 32'd0;

    // Reset state.
    tick(); tick();
    chk("rst_resp", {out_resp1, out_resp2, out_resp3, out_resp4}, 32'd0);
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_op1", alu_op1, 32'd0);

    // Command on the first edge after release must be dropped.
    reset = 1'b1;
    set_req(1, 4'd1, 32'd5);
    tick();
    set_req(1, 4'd0, 32'd0);
    repeat (8) tick();
    chk("sync_drop_valid", 32'(vcnt), 32'd0);
    $display("txn early command after reset release: issues=%0d", vcnt);

    // Basic add on port1, exact T+3 issue / T+5 response timing.
    set_req(1, 4'd1, 32'd1);                    // T
    tick(); set_req(1, 4'd0, 32'h14FFFFFE);     // T+1
    tick(); set_req(1, 4'd0, 32'd0);            // T+2
    tick();                                     // T+3
    chk("t3_valid", 32'(alu_valid), 32'd1);
    chk("t3_op1", alu_op1, 32'd1);
    chk("t3_op2", alu_op2, 32'h14FFFFFE);
    tick();                                     // T+4
    chk("t4_valid_pulse", 32'(alu_valid), 32'd0);
    alu_done = 1'b1; alu_resp = 2'd1; alu_result = 32'h14FFFFFF;
    tick();                                     // T+5
    alu_done = 1'b0; alu_resp = 2'd0; alu_result = 32'd0;
    chk("t5_resp1", 32'(out_resp1), 32'd1);
    chk("t5_data1", out_data1, 32'h14FFFFFF);
    others_zero(1);
    $display("txn port1 add resp=%0d data=%h", out_resp1, out_data1);
    tick();                                     // T+6
    chk("t6_resp1_clear", 32'(out_resp1), 32'd0);

    // Invalid command on port3: error response, no ALU issue.
    v0 = vcnt;
    set_req(3, 4'd7, 32'hDEAD);
    tick(); set_req(3, 4'd0, 32'hBEEF);
    tick(); set_req(3, 4'd0, 32'd0);
    tick();
    chk("inv_resp3", 32'(out_resp3), 32'd2);
    chk("inv_data3", out_data3, 32'd0);
    others_zero(3);
    $display("txn port3 invalid resp=%0d data=%h", out_resp3, out_data3);
    repeat (3) tick();
    chk("inv_no_issue", 32'(vcnt - v0), 32'd0);

    // Port4 extra commands while capturing/pending are dropped.
    v0 = vcnt; r0 = rcnt[3];
    set_req(4, 4'd1, 32'h10);
    tick(); set_req(4, 4'd2, 32'h20);
    tick(); set_req(4, 4'd5, 32'h99);
    tick(); set_req(4, 4'd0, 32'd0);
    serve(4, 32'h10, 32'h20, 32'h30);
    repeat (8) tick();
    chk("drop_one_issue", 32'(vcnt - v0), 32'd1);
    chk("drop_one_resp", 32'(rcnt[3] - r0), 32'd1);

    // All four ports at once: served in order 1,2,3,4.
    r0 = rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3];
    for (int p = 1; p <= 4; p++) set_req(p, 4'd1, 32'(p));
    tick();
    for (int p = 1; p <= 4; p++) set_req(p, 4'd0, 32'(p * 256));
    tick();
    for (int p = 1; p <= 4; p++) set_req(p, 4'd0, 32'd0);
    for (int p = 1; p <= 4; p++) serve(p, 32'(p), 32'(p * 256), 32'(32'h1000 + p));
    repeat (4) tick();
    chk("rr_four_resps", 32'(rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] - r0), 32'd4);

    // After port4, the pointer wraps to port1.
    set_req(1, 4'd1, 32'hA1); set_req(4, 4'd1, 32'hA4);
    tick();
    set_req(1, 4'd0, 32'hB1); set_req(4, 4'd0, 32'hB4);
    tick();
    set_req(1, 4'd0, 32'd0); set_req(4, 4'd0, 32'd0);
    serve(1, 32'hA1, 32'hB1, 32'h1111);
    serve(4, 32'hA4, 32'hB4, 32'h4444);

    // Port2 timeout: silent ALU gives error 16 cycles after issue.
    set_req(2, 4'd1, 32'h2); tick();
    set_req(2, 4'd0, 32'h3); tick();
    set_req(2, 4'd0, 32'd0);
    for (int w = 0; w < 12 && alu_valid !== 1'b1; w++) tick();
    chk("to_issue_seen", 32'(alu_valid), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("to_wait_%0d", k), 32'(out_resp2), 32'd0);
    end
    tick();
    chk("to_resp2", 32'(out_resp2), 32'd2);
    chk("to_data2", out_data2, 32'd0);
    $display("txn port2 timeout resp=%0d data=%h", out_resp2, out_data2);

    // Port2 with done in the last wait cycle: ALU answer wins.
    tick();
    set_req(2, 4'd1, 32'h4); tick();
    set_req(2, 4'd0, 32'h5); tick();
    set_req(2, 4'd0, 32'd0);
    for (int w = 0; w < 12 && alu_valid !== 1'b1; w++) tick();
    chk("late_issue_seen", 32'(alu_valid), 32'd1);
    for (int k = 1; k <= 15; k++) tick();
    alu_done = 1'b1; alu_resp = 2'd1; alu_result = 32'hABCD;
    tick();
    alu_done = 1'b0; alu_resp = 2'd0; alu_result = 32'd0;
    chk("late_resp2", 32'(out_resp2), 32'd1);
    chk("late_data2", out_data2, 32'hABCD);
    $display("txn port2 done-at-limit resp=%0d data=%h", out_resp2, out_data2);
    tick();

    // Reset during WAIT on port3, with a late done after release.
    r0 = rcnt[2];
    set_req(3, 4'd1, 32'h33); tick();
    set_req(3, 4'd0, 32'h44); tick();
    set_req(3, 4'd0, 32'd0);
    for (int w = 0; w < 12 && alu_valid !== 1'b1; w++) tick();
    chk("rw_issue_seen", 32'(alu_valid), 32'd1);
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("rw_cmd_clear", 32'(alu_cmd), 32'd0);
    chk("rw_op1_clear", alu_op1, 32'd0);
    chk("rw_op2_clear", alu_op2, 32'd0);
    chk("rw_resp_clear", {out_resp1, out_resp2, out_resp3, out_resp4}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    alu_done = 1'b1; alu_resp = 2'd1; alu_result = 32'h77;
    tick();
    alu_done = 1'b0; alu_resp = 2'd0; alu_result = 32'd0;
    v0 = vcnt;
    repeat (10) tick();
    chk("rw_no_resp3", 32'(rcnt[2] - r0), 32'd0);
    chk("rw_no_issue", 32'(vcnt - v0), 32'd0);
    $display("txn port3 abandoned by reset: responses=%0d", rcnt[2] - r0);

    // Pointer back at port1 after reset.
    set_req(1, 4'd1, 32'hC1); set_req(4, 4'd1, 32'hC4);
    tick();
    set_req(1, 4'd0, 32'hD1); set_req(4, 4'd0, 32'hD4);
    tick();
    set_req(1, 4'd0, 32'd0); set_req(4, 4'd0, 32'd0);
    serve(1, 32'hC1, 32'hD1, 32'h5151);
    serve(4, 32'hC4, 32'hD4, 32'h5454);
    repeat (4) tick();
    chk("rw_final_no_resp3", 32'(rcnt[2] - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
